// File: rtl/tt_uart_pkg.sv
// ---------------------------------------------------------------------------
// tt_uart_pkg
//   Shared types and constants for the tt_uart receive path.
//   - rx_state_t     : receiver FSM states (PARITY is only reachable when the
//                      design is built with UART_RX_PARITY_EN defined)
//   - UART_DATA_BITS : data bits per UART word
//   - even_parity()  : parity bit a transmitter sends for a data word under
//                      even parity
// ---------------------------------------------------------------------------
package tt_uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // The even-parity bit makes the total count of ones (data + parity) even,
  // which is simply the XOR reduction of the data.
  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/tt_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tt_uart_rx_fifo
//   Generic single-clock FIFO used to buffer received UART bytes.
//   Parameters:
//     WIDTH  data width
//     DEPTH  number of entries; power of 2, >= 2
//   Ports:
//     clk    in   system clock
//     rst_n  in   synchronous reset, active low (empties the FIFO)
//     push   in   write din; accepted when not full, or when full and a pop
//                 happens in the same cycle
//     din    in   write data
//     pop    in   remove the head entry; ignored while empty
//     dout   out  head entry; driven to 0 while empty
//     empty  out  no entries stored
//     full   out  DEPTH entries stored
// ---------------------------------------------------------------------------
module tt_uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             wr_en;
  logic             rd_en;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  // A write into a full FIFO is still safe when the head leaves in the same
  // cycle, because the freed slot is exactly the one being written.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  assign dout = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: dout is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/tt_uart_rx.sv
// ---------------------------------------------------------------------------
// tt_uart_rx
//   UART receiver feeding the user-logic core of the tt_um top. Deframes
//   8-bit LSB-first words from a serial line, buffers them in a small FIFO
//   and presents them on a valid/ready interface.
//   Optional feature macro: UART_RX_PARITY_EN
//     defined   -> 8E1 frames (11 bits), parity_err_o reports mismatches
//     undefined -> 8N1 frames (10 bits), parity_err_o tied to 0
//   Parameters:
//     CLKS_PER_BIT  clk cycles per UART bit (>= 4)
//     FIFO_DEPTH    receive FIFO entries (power of 2, >= 2)
//   Ports:
//     clk           in   system clock
//     rst_n         in   synchronous reset, active low
//     ena           in   low holds the receiver idle; FIFO keeps its data
//     rx_i          in   asynchronous serial input, idle high
//     data_o        out  FIFO head byte, valid while valid_o = 1
//     valid_o       out  FIFO not empty
//     ready_i       in   consumer takes data_o when valid_o && ready_i
//     frame_err_o   out  1-cycle pulse: stop bit sampled low
//     overrun_o     out  1-cycle pulse: completed byte dropped, FIFO full
//     parity_err_o  out  1-cycle pulse: parity mismatch
// ---------------------------------------------------------------------------
module tt_uart_rx
  import tt_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic                      rx_i,
  output logic [UART_DATA_BITS-1:0] data_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic                      frame_err_o,
  output logic                      overrun_o,
  output logic                      parity_err_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(UART_DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(UART_DATA_BITS - 1);

  rx_state_t                 state;
  rx_state_t                 state_next;

  logic                      rx_meta;
  logic                      rx_sync;
  logic                      rx_prev;
  logic [CNT_W-1:0]          bit_cnt;
  logic [IDX_W-1:0]          bit_idx;
  logic [UART_DATA_BITS-1:0] shift_reg;
  logic                      parity_bad;

  logic                      start_edge;
  logic                      bit_tick;
  logic                      half_tick;
  logic                      parity_mismatch;

  logic                      push_req;
  logic                      pop;
  logic                      fifo_empty;
  logic                      fifo_full;

  // A start bit is a falling edge of the synchronized line; requiring the
  // edge (not just a low level) stops a line stuck low after a framing error
  // from being mistaken for a stream of new frames.
  assign start_edge      = rx_prev && !rx_sync;
  assign half_tick       = (bit_cnt == HALF_CNT);
  assign bit_tick        = (bit_cnt == FULL_CNT);
  assign parity_mismatch = (rx_sync != even_parity(shift_reg));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. START is checked at mid-bit so every later sample,
  // spaced a full bit apart, also lands mid-bit. STOP returns to IDLE at the
  // middle of the stop bit, leaving half a bit of slack for the next start
  // edge of a back-to-back frame.
  always_comb begin
    state_next = state;
    if (!ena) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start_edge) begin
            state_next = START;
          end
        end
        START: begin
          if (half_tick) begin
            state_next = rx_sync ? IDLE : DATA;
          end
        end
        DATA: begin
          if (bit_tick && (bit_idx == LAST_BIT)) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
        PARITY: begin
          if (bit_tick) begin
            state_next = STOP;
          end
        end
        STOP: begin
          if (bit_tick) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Synchronizer, bit timing and data capture. The bit counter restarts in
  // IDLE and whenever the receiver is disabled, so an aborted frame leaves
  // nothing behind.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      parity_bad <= 1'b0;
    end else begin
      rx_meta <= rx_i;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;

      if (!ena || (state == IDLE)) begin
        bit_cnt    <= '0;
        bit_idx    <= '0;
        parity_bad <= 1'b0;
      end else if (state == START) begin
        bit_cnt <= half_tick ? '0 : bit_cnt + CNT_W'(1);
      end else begin
        bit_cnt <= bit_tick ? '0 : bit_cnt + CNT_W'(1);
      end

      if (ena && (state == DATA) && bit_tick) begin
        shift_reg <= {rx_sync, shift_reg[UART_DATA_BITS-1:1]};
        bit_idx   <= bit_idx + IDX_W'(1);
      end

      if (ena && (state == PARITY) && bit_tick) begin
        parity_bad <= parity_mismatch;
      end
    end
  end

  // Output logic: the stop-bit sample either hands the byte to the FIFO or
  // flags a framing error. A byte with bad parity is dropped silently here
  // because its error was already reported at the parity sample.
  always_comb begin
    push_req     = 1'b0;
    frame_err_o  = 1'b0;
    parity_err_o = 1'b0;
    if (ena) begin
      case (state)
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (bit_tick && parity_mismatch) begin
            parity_err_o = 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_tick) begin
            if (rx_sync) begin
              push_req = !parity_bad;
            end else begin
              frame_err_o = 1'b1;
            end
          end
        end
        default: begin
          push_req = 1'b0;
        end
      endcase
    end
  end

  assign valid_o   = !fifo_empty;
  assign pop       = valid_o && ready_i;
  assign overrun_o = push_req && fifo_full && !pop;

  tt_uart_rx_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .din   (shift_reg),
    .pop   (pop),
    .dout  (data_o),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule
